bus_cycle_unit: RTL and testbench

- Memory-cycle sequencer and address incrementer (IDU). Sits directly downstream of the PC/SP/temp-register block.
- Per request, captures a 16-bit address and an optional write byte from the internal address buses and internal databus, then runs one 4-state M-cycle on the external bus.
- Returns read data for the IR/Z/W latches, plus the incremented, decremented or passed-through address for PC/SP writeback.

---
 rtl/bus_cycle_unit_pkg.sv | 29 ++
 rtl/bus_cycle_unit_idu.sv | 22 ++
 rtl/bus_cycle_unit.sv | 162 ++++++++++++++++
 tb/tb_bus_cycle_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_cycle_unit_pkg.sv
// Shared types and constants for the bus cycle sequencer and its address incrementer.
package bus_cycle_unit_pkg;

  // M-cycle states: idle plus the four T-states of one bus cycle.
  typedef enum logic [2:0] {
    StIdle,
    StT1,
    StT2,
    StT3,
    StT4
  } state_e;

  // IDU operation encodings; 2'b11 behaves as pass.
  localparam logic [1:0] IduPass  = 2'b00;
  localparam logic [1:0] IduInc   = 2'b01;
  localparam logic [1:0] IduDec   = 2'b10;
  localparam logic [1:0] IduPass2 = 2'b11;

  // First address of the internal high region, which never asserts chip select.
  localparam logic [15:0] HiBaseDefault = 16'hFE00;

  // External strobes are active low.
  localparam logic StrobeInactive = 1'b1;
  localparam logic StrobeActive   = 1'b0;

  // Read data value at reset and after a timed-out read.
  localparam logic [7:0] RdataIdle = 8'hFF;

endpackage

// File: rtl/bus_cycle_unit_idu.sv
// Combinational pass / +1 / -1 unit; also usable for direct SP/PC increment.
module idu_inc
  import bus_cycle_unit_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] addr_i,
  input  logic [1:0]       op_i,
  output logic [Width-1:0] res_o
);

  // Modulo arithmetic: wraps naturally at the width boundary.
  always_comb begin
    res_o = addr_i;
    unique case (op_i)
      IduInc:  res_o = addr_i + Width'(1);
      IduDec:  res_o = addr_i - Width'(1);
      default: res_o = addr_i;
    endcase
  end

endmodule

// File: rtl/bus_cycle_unit.sv
// Memory-cycle sequencer: captures an address/write byte per request, runs one
// T1..T4 cycle on the external bus and returns read data plus an IDU result.
module bus_cycle_unit
  import bus_cycle_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       MAX_WAIT = 15,
  parameter logic [ADDR_W-1:0] HI_BASE  = ADDR_W'(HiBaseDefault)
) (
  input  logic                CLK,
  input  logic                SYNC_RES,
  input  logic                req,
  output logic                ack,
  input  logic                wr,
  input  logic [ADDR_W/2-1:0] adl,
  input  logic [ADDR_W/2-1:0] adh,
  input  logic [DATA_W-1:0]   dl_wdata,
  input  logic [1:0]          idu_op,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   dl_rdata,
  output logic [ADDR_W-1:0]   idu_q,
  output logic                timeout,
  output logic [ADDR_W-1:0]   ext_a,
  output logic [DATA_W-1:0]   ext_d_out,
  output logic                ext_d_oe,
  input  logic [DATA_W-1:0]   ext_d_in,
  output logic                ext_nrd,
  output logic                ext_nwr,
  output logic                ext_ncs,
  input  logic                ext_wait
);

  localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [1:0]        op_q, op_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] idu_res_q, idu_res_d;
  logic              timeout_q, timeout_d;

  logic              accept;
  logic              wait_expired;
  logic [ADDR_W-1:0] idu_res;

  assign accept       = req && ((state_q == StIdle) || (state_q == StT4));
  assign wait_expired = (state_q == StT3) && (wait_cnt_q == MaxWaitCnt);

  idu_inc #(
    .Width (ADDR_W)
  ) u_idu (
    .addr_i (addr_q),
    .op_i   (op_q),
    .res_o  (idu_res)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (SYNC_RES) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; T3 stretches on ext_wait until the wait budget runs out.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StT1;
      StT1:    state_d = StT2;
      StT2:    state_d = StT3;
      StT3:    if (wait_expired || !ext_wait) state_d = StT4;
      StT4:    state_d = accept ? StT1 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath register bank.
  always_ff @(posedge CLK) begin
    if (SYNC_RES) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      op_q       <= IduPass;
      wait_cnt_q <= '0;
      rdata_q    <= DATA_W'(RdataIdle);
      idu_res_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      idu_res_q  <= idu_res_d;
      timeout_q  <= timeout_d;
    end
  end

  // Datapath next-state: latch on accept, count waits and capture results on T3 exit.
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    op_d       = op_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    idu_res_d  = idu_res_q;
    timeout_d  = timeout_q;
    if (accept) begin
      addr_d     = {adh, adl};
      wdata_d    = dl_wdata;
      wr_d       = wr;
      op_d       = idu_op;
      wait_cnt_d = '0;
      timeout_d  = 1'b0;
    end else if (state_q == StT3) begin
      if (wait_expired) begin
        // Forced completion: the read data is not trustworthy.
        timeout_d = 1'b1;
        idu_res_d = idu_res;
        if (!wr_q) rdata_d = DATA_W'(RdataIdle);
      end else if (!ext_wait) begin
        idu_res_d = idu_res;
        if (!wr_q) rdata_d = ext_d_in;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end
  end

  // Output decode from state and latched cycle attributes.
  always_comb begin
    logic in_t1_t3;
    logic in_t2_t3;
    logic in_t2_t4;
    in_t1_t3  = (state_q == StT1) || (state_q == StT2) || (state_q == StT3);
    in_t2_t3  = (state_q == StT2) || (state_q == StT3);
    in_t2_t4  = in_t2_t3 || (state_q == StT4);
    ack       = accept;
    busy      = (state_q != StIdle);
    done      = (state_q == StT4);
    dl_rdata  = rdata_q;
    idu_q     = idu_res_q;
    timeout   = timeout_q;
    ext_a     = busy ? addr_q : '0;
    ext_ncs   = (in_t1_t3 && (addr_q < HI_BASE)) ? StrobeActive : StrobeInactive;
    ext_nrd   = (in_t1_t3 && !wr_q) ? StrobeActive : StrobeInactive;
    ext_nwr   = (in_t2_t3 && wr_q) ? StrobeActive : StrobeInactive;
    ext_d_oe  = in_t2_t4 && wr_q;
    ext_d_out = ext_d_oe ? wdata_q : '0;
  end

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Scoreboard bench for bus_cycle_unit: stimulus pushes expected completions,
// a negedge monitor checks each done pulse against the queue.
module tb_bus_cycle_unit;

  logic        CLK = 1'b0;
  logic        SYNC_RES;
  logic        req, ack, wr, busy, done, timeout;
  logic [7:0]  adl, adh, dl_wdata, dl_rdata, ext_d_out, ext_d_in;
  logic [1:0]  idu_op;
  logic [15:0] idu_q, ext_a;
  logic        ext_d_oe, ext_nrd, ext_nwr, ext_ncs, ext_wait;

  bus_cycle_unit dut (
    .CLK       (CLK),
    .SYNC_RES  (SYNC_RES),
    .req       (req),
    .ack       (ack),
    .wr        (wr),
    .adl       (adl),
    .adh       (adh),
    .dl_wdata  (dl_wdata),
    .idu_op    (idu_op),
    .busy      (busy),
    .done      (done),
    .dl_rdata  (dl_rdata),
    .idu_q     (idu_q),
    .timeout   (timeout),
    .ext_a     (ext_a),
    .ext_d_out (ext_d_out),
    .ext_d_oe  (ext_d_oe),
    .ext_d_in  (ext_d_in),
    .ext_nrd   (ext_nrd),
    .ext_nwr   (ext_nwr),
    .ext_ncs   (ext_ncs),
    .ext_wait  (ext_wait)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cyc;
    logic [7:0]  rd;
    logic [15:0] iq;
    logic        to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge CLK) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc, mon_e.cyc);
        check("dl_rdata", {24'd0, dl_rdata}, {24'd0, mon_e.rd});
        check("idu_q", {16'd0, idu_q}, {16'd0, mon_e.iq});
        check("timeout", {31'd0, timeout}, {31'd0, mon_e.to});
      end
    end
  end

  // Raise req, wait (bounded) for ack, push expectation; lat==0 means no done expected.
  task automatic issue(input logic [15:0] a, input logic w, input logic [7:0] d,
                       input logic [1:0] op, input logic [7:0] erd, input logic [15:0] eiq,
                       input logic eto, input int lat, output int c);
    @(negedge CLK);
    {adh, adl} = a;
    wr         = w;
    dl_wdata   = d;
    idu_op     = op;
    req        = 1'b1;
    c          = -1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (ack) begin
        c = cyc;
        break;
      end
      @(negedge CLK);
      #1;
    end
    if (c < 0) begin
      total++;
      bad++;
      $display("FAIL ack_wait: got no ack want ack for addr %h", a);
      req = 1'b0;
    end else begin
      if (lat > 0) sb.push_back(exp_t'{cyc: c + lat, rd: erd, iq: eiq, to: eto});
      @(posedge CLK);
      #1;
      req = 1'b0;
    end
  endtask

  // Check {ncs,nrd,nwr,oe}, address and write data over T1..T4; call in T1.
  task automatic strobes(input string name, input logic [15:0] exp, input logic [15:0] a,
                         input logic [7:0] wd);
    for (int k = 0; k < 4; k++) begin
      check(name, {28'd0, ext_ncs, ext_nrd, ext_nwr, ext_d_oe}, {28'd0, exp[15-4*k -: 4]});
      check("ext_a", {16'd0, ext_a}, {16'd0, a});
      if (exp[15-4*k-3]) check("ext_d_out", {24'd0, ext_d_out}, {24'd0, wd});
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int c, c1, c2;
    SYNC_RES = 1'b1;
    req      = 1'b0;
    wr       = 1'b0;
    adl      = '0;
    adh      = '0;
    dl_wdata = '0;
    idu_op   = '0;
    ext_d_in = '0;
    ext_wait = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_strobes", {28'd0, ext_ncs, ext_nrd, ext_nwr, ext_d_oe}, 32'hE);
    check("rst_ext_a", {16'd0, ext_a}, 32'h0);
    check("rst_ext_d_out", {24'd0, ext_d_out}, 32'h0);
    check("rst_dl_rdata", {24'd0, dl_rdata}, 32'hFF);
    check("rst_idu_q", {16'd0, idu_q}, 32'h0);
    check("rst_flags", {28'd0, ack, done, busy, timeout}, 32'h0);
    SYNC_RES = 1'b0;

    // Read, no wait, low region.
    ext_d_in = 8'h3E;
    issue(16'h0150, 1'b0, 8'h00, 2'b01, 8'h3E, 16'h0151, 1'b0, 4, c);
    strobes("rd_strobes", 16'h222E, 16'h0150, 8'h00);

    // Write to the high region: no chip select, read data untouched.
    issue(16'hFF80, 1'b1, 8'hA5, 2'b10, 8'h3E, 16'hFF7F, 1'b0, 4, c);
    strobes("wr_strobes", 16'hEDDF, 16'hFF80, 8'hA5);

    // Three wait states in T3.
    ext_wait = 1'b1;
    ext_d_in = 8'h00;
    issue(16'h0200, 1'b0, 8'h00, 2'b00, 8'h12, 16'h0200, 1'b0, 7, c);
    while (cyc < c + 6) @(negedge CLK);
    ext_wait = 1'b0;
    ext_d_in = 8'h12;
    repeat (4) @(negedge CLK);

    // Wait held high: forced completion after the wait budget.
    ext_wait = 1'b1;
    issue(16'h1234, 1'b0, 8'h00, 2'b01, 8'hFF, 16'h1235, 1'b1, 19, c);
    repeat (22) @(negedge CLK);
    check("timeout_sticky", {31'd0, timeout}, 32'h1);
    check("idle_after_timeout", {31'd0, busy}, 32'h0);
    ext_wait = 1'b0;

    // Wrap and back-to-back: second request held across the first cycle.
    ext_d_in = 8'h5A;
    issue(16'hFFFF, 1'b0, 8'h00, 2'b01, 8'h5A, 16'h0000, 1'b0, 4, c1);
    check("timeout_cleared", {31'd0, timeout}, 32'h0);
    issue(16'h0000, 1'b0, 8'h00, 2'b10, 8'h5A, 16'hFFFF, 1'b0, 4, c2);
    check("b2b_ack_in_t4", c2, c1 + 4);
    while (cyc <= c2 + 4) begin
      check("b2b_busy", {31'd0, busy}, 32'h1);
      @(negedge CLK);
    end
    repeat (3) @(negedge CLK);

    // Reset during T2 of a write aborts the cycle without a done.
    issue(16'h0300, 1'b1, 8'h77, 2'b01, 8'h00, 16'h0000, 1'b0, 0, c);
    while (cyc < c + 2) @(negedge CLK);
    check("pre_reset_nwr", {31'd0, ext_nwr}, 32'h0);
    SYNC_RES = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_strobes", {28'd0, ext_ncs, ext_nrd, ext_nwr, ext_d_oe}, 32'hE);
    check("abort_busy_done", {30'd0, busy, done}, 32'h0);
    check("abort_dl_rdata", {24'd0, dl_rdata}, 32'hFF);
    check("abort_idu_q", {16'd0, idu_q}, 32'h0);
    SYNC_RES = 1'b0;
    repeat (10) @(negedge CLK);

    check("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

endmodule
